// File: rtl/riscv_csr_ctrl_pkg.sv
// Shared constants and types for the CSR requester: op codes, machine-mode CSR
// addresses, the ECALL cause value and the controller state encoding.
package riscv_constants;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;

  localparam logic [CSR_AW-1:0] CSR_MTVEC  = 12'h305;
  localparam logic [CSR_AW-1:0] CSR_MEPC   = 12'h341;
  localparam logic [CSR_AW-1:0] CSR_MCAUSE = 12'h342;

  localparam int CAUSE_ECALL_M = 11;

  // Encodings 6 and 7 are reserved and reported as illegal.
  typedef enum logic [2:0] {
    CSR_OP_NONE  = 3'd0,
    CSR_OP_RW    = 3'd1,
    CSR_OP_RS    = 3'd2,
    CSR_OP_RC    = 3'd3,
    CSR_OP_ECALL = 3'd4,
    CSR_OP_MRET  = 3'd5
  } csr_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_T_EPC,
    ST_T_CAUSE,
    ST_T_VEC,
    ST_M_EPC,
    ST_RESP
  } csr_ctrl_state_t;

endpackage

// File: rtl/riscv_csr_alu.sv
// Read-modify-write value for Zicsr ops. Set/clear with a zero mask leave the
// CSR untouched, so they report do_write=0 and no write is issued.
module riscv_csr_alu
  import riscv_constants::*;
#(
  parameter int W = XLEN
) (
  input  logic [2:0]   op,
  input  logic [W-1:0] old_value,
  input  logic [W-1:0] src,
  output logic [W-1:0] new_value,
  output logic         do_write
);

  // NOTE: every combinational output gets a default before the case, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    new_value = '0;
    do_write  = 1'b0;
    case (op)
      CSR_OP_RW: begin
        new_value = src;
        do_write  = 1'b1;
      end
      CSR_OP_RS: begin
        new_value = old_value | src;
        do_write  = (src != '0);
      end
      CSR_OP_RC: begin
        new_value = old_value & ~src;
        do_write  = (src != '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_csr_ctrl.sv
// CSR register-file requester: takes one CSR instruction from execute, sequences
// the CSR file reads/writes (RMW, ECALL trap entry, MRET), and returns the result.
module riscv_csr_ctrl
  import riscv_constants::*;
#(
  parameter int                    WORD_LENGTH = XLEN,
  parameter int                    CSR_ADDR_W  = CSR_AW,
  parameter logic [CSR_ADDR_W-1:0] MTVEC_ADDR  = CSR_MTVEC,
  parameter logic [CSR_ADDR_W-1:0] MEPC_ADDR   = CSR_MEPC,
  parameter logic [CSR_ADDR_W-1:0] MCAUSE_ADDR = CSR_MCAUSE,
  parameter int                    ECALL_CAUSE = CAUSE_ECALL_M
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [CSR_ADDR_W-1:0]  req_addr,
  input  logic [WORD_LENGTH-1:0] req_src,
  input  logic [WORD_LENGTH-1:0] req_pc,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WORD_LENGTH-1:0] rsp_rdata,
  output logic                   rsp_redirect,
  output logic [WORD_LENGTH-1:0] rsp_target,
  output logic                   rsp_illegal,
  output logic                   csr_wen,
  output logic [CSR_ADDR_W-1:0]  csr_addr,
  output logic [WORD_LENGTH-1:0] csr_wdata,
  input  logic [WORD_LENGTH-1:0] csr_rdata
);

  // Direct-mode trap vector: the low two mode bits of mtvec are not part of the PC.
  localparam logic [WORD_LENGTH-1:0] VEC_MASK = ~WORD_LENGTH'(3);

  csr_ctrl_state_t        state_q, state_d;
  logic [2:0]             op_q;
  logic [CSR_ADDR_W-1:0]  addr_q;
  logic [WORD_LENGTH-1:0] src_q, pc_q, new_q, rdata_q, target_q;
  logic                   redirect_q, illegal_q;
  logic [WORD_LENGTH-1:0] alu_new;
  logic                   alu_do_write;
  logic                   accept;

  assign accept = req_valid && (state_q == ST_IDLE);

  riscv_csr_alu #(.W(WORD_LENGTH)) u_alu (
    .op        (op_q),
    .old_value (csr_rdata),
    .src       (src_q),
    .new_value (alu_new),
    .do_write  (alu_do_write)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Write strobe and address are decoded from state alone, so an asynchronous
  // reset that returns state to IDLE kills any in-flight write immediately.
  always_comb begin
    state_d   = state_q;
    csr_wen   = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          case (req_op)
            CSR_OP_RW, CSR_OP_RS, CSR_OP_RC: state_d = ST_READ;
            CSR_OP_ECALL:                    state_d = ST_T_EPC;
            CSR_OP_MRET:                     state_d = ST_M_EPC;
            default:                         state_d = ST_RESP;
          endcase
        end
      end
      ST_READ: begin
        csr_addr = addr_q;
        state_d  = alu_do_write ? ST_WRITE : ST_RESP;
      end
      ST_WRITE: begin
        csr_wen   = 1'b1;
        csr_addr  = addr_q;
        csr_wdata = new_q;
        state_d   = ST_RESP;
      end
      ST_T_EPC: begin
        csr_wen   = 1'b1;
        csr_addr  = MEPC_ADDR;
        csr_wdata = pc_q;
        state_d   = ST_T_CAUSE;
      end
      ST_T_CAUSE: begin
        csr_wen   = 1'b1;
        csr_addr  = MCAUSE_ADDR;
        csr_wdata = WORD_LENGTH'(ECALL_CAUSE);
        state_d   = ST_T_VEC;
      end
      ST_T_VEC: begin
        csr_addr = MTVEC_ADDR;
        state_d  = ST_RESP;
      end
      ST_M_EPC: begin
        csr_addr = MEPC_ADDR;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= '0;
      addr_q     <= '0;
      src_q      <= '0;
      pc_q       <= '0;
      new_q      <= '0;
      rdata_q    <= '0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= req_op;
            addr_q     <= req_addr;
            src_q      <= req_src;
            pc_q       <= req_pc;
            new_q      <= '0;
            rdata_q    <= '0;
            target_q   <= '0;
            redirect_q <= 1'b0;
            illegal_q  <= !(req_op inside {CSR_OP_RW, CSR_OP_RS, CSR_OP_RC,
                                           CSR_OP_ECALL, CSR_OP_MRET});
          end
        end
        ST_READ: begin
          rdata_q <= csr_rdata;
          new_q   <= alu_new;
        end
        ST_T_VEC: begin
          target_q   <= csr_rdata & VEC_MASK;
          redirect_q <= 1'b1;
        end
        ST_M_EPC: begin
          target_q   <= csr_rdata;
          redirect_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // req_ready is gated by rst_n so it reads 0 for the whole reset window.
  assign req_ready    = rst_n && (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rdata_q;
  assign rsp_redirect = redirect_q;
  assign rsp_target   = target_q;
  assign rsp_illegal  = illegal_q;

endmodule
